// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side handshakes and the memory-side bus for mem_arbiter.
// slave = arbiter view, master = core/memory environment view.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_ready;
  logic [DW-1:0] i_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ready;
  logic [DW-1:0] d_rdata;
  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  logic          busy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    output i_ready, i_rdata, d_ready, d_rdata, m_en, m_we, m_addr, m_wdata, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    input  i_ready, i_rdata, d_ready, d_rdata, m_en, m_we, m_addr, m_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency single-port memory between instruction fetch and
// data access ports; ties alternate so neither side can starve.
module mem_arbiter #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int LAT = 2
) (
  input logic         clk,
  input logic         reset,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;
  localparam int   CW    = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0] CNT_RD = CW'(LAT - 1);

  state_t        state_q;
  logic          last_grant_q;
  logic          owner_q;
  logic [CW-1:0] cnt_q;
  logic          i_ready_q, d_ready_q;
  logic [DW-1:0] i_rdata_q, d_rdata_q;
  logic          m_en_q, m_we_q;
  logic [AW-1:0] m_addr_q;
  logic [DW-1:0] m_wdata_q;

  logic          owner_d;
  logic          we_d;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] wdata_d;

  // On a tie the side that did not win last time gets the memory.
  always_comb begin
    owner_d = OWN_I;
    if (bus.i_req && bus.d_req) owner_d = ~last_grant_q;
    else if (bus.d_req)         owner_d = OWN_D;
    we_d    = (owner_d == OWN_D) && bus.d_we;
    addr_d  = (owner_d == OWN_D) ? bus.d_addr : bus.i_addr;
    wdata_d = (owner_d == OWN_D) ? bus.d_wdata : m_wdata_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= OWN_I;
      owner_q      <= OWN_I;
      cnt_q        <= '0;
      i_ready_q    <= 1'b0;
      d_ready_q    <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      m_en_q       <= 1'b0;
      m_we_q       <= 1'b0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
    end else begin
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.i_req || bus.d_req) begin
            owner_q   <= owner_d;
            m_en_q    <= 1'b1;
            m_we_q    <= we_d;
            m_addr_q  <= addr_d;
            m_wdata_q <= wdata_d;
            cnt_q     <= we_d ? '0 : CNT_RD;
            state_q   <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            // m_rdata is only guaranteed on the final cycle of the read window.
            if (!m_we_q) begin
              if (owner_q == OWN_D) d_rdata_q <= bus.m_rdata;
              else                  i_rdata_q <= bus.m_rdata;
            end
            i_ready_q <= (owner_q == OWN_I);
            d_ready_q <= (owner_q == OWN_D);
            m_en_q    <= 1'b0;
            m_we_q    <= 1'b0;
            state_q   <= RESP;
          end
        end
        RESP: begin
          last_grant_q <= owner_q;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.i_ready = i_ready_q;
  assign bus.d_ready = d_ready_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.m_en    = m_en_q;
  assign bus.m_we    = m_we_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.busy    = (state_q != IDLE);
endmodule
